sdram_read: RTL and testbench

- SDRAM burst-read engine; the read-side counterpart of sdram_write, sharing its command, bank and address bus format.
- Runs in the 100 MHz controller domain. The SDRAM clock is a phase-shifted copy of that clock.
- Per request it issues ACTIVE, READ, BURST TERMINATE and PRECHARGE, honouring tRCD, CAS latency and tRP.
- It captures up to one full page of 16-bit words from the DQ bus and presents them to the user side with a per-word ack, then pulses done.

---
 rtl/sdram_read.sv | 193 +++++++++++++++++++
 tb/tb_sdram_read.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read.sv
// SDRAM burst-read engine: ACTIVE/READ/BST/PRECHARGE sequencing with per-word capture from DQ.
// Optional SDRAM_RD_DQ_REG_EN adds an input register on DQ (data, ack, PRE and done one cycle later).
module sdram_read #(
    parameter int unsigned TRCD_CLK = 2,
    parameter int unsigned CAS_LAT  = 3,
    parameter int unsigned TRP_CLK  = 2,
    parameter int unsigned PAGE_LEN = 512
) (
    input  logic        i_sysclk,
    input  logic        i_sysrst_n,
    input  logic        i_init_done,
    input  logic [23:0] i_rd_addr,
    input  logic [9:0]  i_rd_burst_len,
    input  logic        i_read_start,
    input  logic [15:0] i_sdram_dq,
    output logic [3:0]  o_rd_cmd,
    output logic [1:0]  o_rd_ba,
    output logic [12:0] o_rd_addr,
    output logic [15:0] o_rd_data,
    output logic        o_rd_ack,
    output logic        o_rd_done
);

    localparam logic [3:0] CmdNop  = 4'b0111;
    localparam logic [3:0] CmdAct  = 4'b0011;
    localparam logic [3:0] CmdRead = 4'b0101;
    localparam logic [3:0] CmdBst  = 4'b0110;
    localparam logic [3:0] CmdPre  = 4'b0010;

    localparam logic [9:0] CasW     = 10'(CAS_LAT);
    localparam logic [9:0] PageW    = 10'(PAGE_LEN);
    localparam logic [9:0] TrcdLast = 10'((TRCD_CLK > 1) ? TRCD_CLK - 2 : 0);
    localparam logic [9:0] TrpLast  = 10'((TRP_CLK > 1) ? TRP_CLK - 2 : 0);

    typedef enum logic [2:0] {
        StIdle, StAct, StTrcd, StRd, StClData, StPre, StTrp, StEnd
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [9:0]  len_q, len_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [1:0]  ba_q, ba_d;
    logic [12:0] sd_addr_q, sd_addr_d;
    logic [15:0] data_q, data_d;
    logic        ack_q, ack_d;
    logic        done_q, done_d;
    logic [15:0] dq_cap;

`ifdef SDRAM_RD_DQ_REG_EN
    localparam logic [9:0] DqDly = 10'd1;
    logic [15:0] dq_q;

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            dq_q <= '0;
        end else begin
            dq_q <= i_sdram_dq;
        end
    end
    assign dq_cap = dq_q;
`else
    localparam logic [9:0] DqDly = 10'd0;
    assign dq_cap = i_sdram_dq;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        unique case (state_q)
            StIdle: begin
                if (i_init_done && i_read_start) begin
                    state_d = StAct;
                    addr_d  = i_rd_addr;
                    if (i_rd_burst_len == 10'd0) begin
                        len_d = 10'd1;
                    end else if (i_rd_burst_len > PageW) begin
                        len_d = PageW;
                    end else begin
                        len_d = i_rd_burst_len;
                    end
                end
            end
            StAct: begin
                cnt_d   = '0;
                state_d = (TRCD_CLK > 1) ? StTrcd : StRd;
            end
            StTrcd: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q >= TrcdLast) begin
                    state_d = StRd;
                    cnt_d   = '0;
                end
            end
            // cnt counts cycles since the READ command from here until PRECHARGE
            StRd: begin
                state_d = StClData;
                cnt_d   = 10'd1;
            end
            StClData: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == CasW + len_q - 10'd1 + DqDly) begin
                    state_d = StPre;
                    cnt_d   = '0;
                end
            end
            StPre: begin
                cnt_d   = '0;
                state_d = (TRP_CLK > 1) ? StTrp : StEnd;
            end
            StTrp: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q >= TrpLast) begin
                    state_d = StEnd;
                    cnt_d   = '0;
                end
            end
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Bus outputs are decoded from the next state so they leave the flops aligned with it
        cmd_d     = CmdNop;
        ba_d      = 2'b11;
        sd_addr_d = 13'h1FFF;
        case (state_d)
            StAct: begin
                cmd_d     = CmdAct;
                ba_d      = addr_d[23:22];
                sd_addr_d = addr_d[21:9];
            end
            StRd: begin
                cmd_d     = CmdRead;
                ba_d      = addr_d[23:22];
                sd_addr_d = {4'b0000, addr_d[8:0]};
            end
            StClData: begin
                if (cnt_d == len_d) begin
                    cmd_d = CmdBst;
                    ba_d  = addr_d[23:22];
                end
            end
            StPre: begin
                cmd_d     = CmdPre;
                ba_d      = addr_d[23:22];
                sd_addr_d = 13'h0000;
            end
            default: ;
        endcase

        done_d = (state_d == StEnd);
        ack_d  = (state_q == StClData) && (cnt_q >= CasW + DqDly) &&
                 (cnt_q < CasW + DqDly + len_q);
        data_d = ack_d ? dq_cap : data_q;
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            len_q     <= 10'd1;
            cmd_q     <= CmdNop;
            ba_q      <= 2'b11;
            sd_addr_q <= 13'h1FFF;
            data_q    <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            ba_q      <= ba_d;
            sd_addr_q <= sd_addr_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    assign o_rd_cmd  = cmd_q;
    assign o_rd_ba   = ba_q;
    assign o_rd_addr = sd_addr_q;
    assign o_rd_data = data_q;
    assign o_rd_ack  = ack_q;
    assign o_rd_done = done_q;

endmodule

// File: tb/tb_sdram_read.sv
// Self-checking bench for sdram_read: behavioural SDRAM on DQ, table vectors, random transfers,
// guard, start-drop and mid-transfer reset sequences.
module tb_sdram_read;

    localparam int CAS  = 3;
    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam int PAGE = 512;
`ifdef SDRAM_RD_DQ_REG_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    localparam logic [3:0] CmdNop  = 4'b0111;
    localparam logic [3:0] CmdAct  = 4'b0011;
    localparam logic [3:0] CmdRead = 4'b0101;
    localparam logic [3:0] CmdBst  = 4'b0110;
    localparam logic [3:0] CmdPre  = 4'b0010;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        init_done = 1'b0;
    logic        start     = 1'b0;
    logic [23:0] rd_addr   = '0;
    logic [9:0]  burst_len = '0;
    logic [15:0] dq        = '0;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] sd_addr;
    logic [15:0] rdata;
    logic        ack;
    logic        done;

    int cyc   = 0;
    int npass = 0;
    int nchk  = 0;

    sdram_read dut (
        .i_sysclk      (clk),
        .i_sysrst_n    (rst_n),
        .i_init_done   (init_done),
        .i_rd_addr     (rd_addr),
        .i_rd_burst_len(burst_len),
        .i_read_start  (start),
        .i_sdram_dq    (dq),
        .o_rd_cmd      (cmd),
        .o_rd_ba       (ba),
        .o_rd_addr     (sd_addr),
        .o_rd_data     (rdata),
        .o_rd_ack      (ack),
        .o_rd_done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: bank 0 / row 0 holds its column index.
    function automatic logic [15:0] mem_word(input logic [1:0] b, input logic [12:0] r,
                                             input logic [8:0] c);
        return {7'd0, c} ^ ({3'd0, r} << 3) ^ {b, 14'd0};
    endfunction

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > PAGE) return PAGE;
        return l;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Behavioural SDRAM: full-page burst, word i on DQ during cycle READ+CAS+i, cut off by BST.
    logic [12:0] open_row [4];
    bit          rd_on = 1'b0;
    int          rd_cyc_m = 0;
    int          bst_cyc_m = 0;
    logic [1:0]  rd_ba_m = '0;
    logic [12:0] rd_row_m = '0;
    logic [8:0]  rd_col_m = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_on = 1'b0;
        end else begin
            case (cmd)
                CmdAct: open_row[ba] = sd_addr;
                CmdRead: begin
                    rd_on     = 1'b1;
                    rd_cyc_m  = cyc;
                    bst_cyc_m = cyc + 100000;
                    rd_ba_m   = ba;
                    rd_row_m  = open_row[ba];
                    rd_col_m  = sd_addr[8:0];
                end
                CmdBst:  bst_cyc_m = cyc;
                CmdPre:  rd_on = 1'b0;
                default: ;
            endcase
        end
        if (rd_on && cyc >= rd_cyc_m + CAS && cyc < bst_cyc_m + CAS)
            dq = mem_word(rd_ba_m, rd_row_m, 9'(cyc - rd_cyc_m - CAS + int'(rd_col_m)));
        else
            dq = 16'($urandom);
    end

    task automatic run_xfer(input string tag, input logic [23:0] a, input logic [9:0] l,
                            input logic [1:0] eba, input logic [12:0] erow,
                            input logic [8:0] ecol, input int en, input bit drop);
        int act_c = -1, rd_c = -1, bst_c = -1, pre_c = -1, done_c = -1;
        int n_act = 0, n_done = 0, n_ack = 0, first_ack = -1, last_ack = -1;
        int bad_bus = 0, bad_data = 0, gaps = 0, post = -1;
        logic [1:0]  act_ba = '0, rd_ba = '0, bst_ba = '0, pre_ba = '0;
        logic [12:0] act_a = '0, rd_a = '0;
        logic        pre_a10 = 1'b1;
        @(negedge clk);
        rd_addr   = a;
        burst_len = l;
        start     = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            case (cmd)
                CmdAct: begin
                    n_act++;
                    act_c = cyc; act_ba = ba; act_a = sd_addr;
                    rd_addr   = ~a;
                    burst_len = 10'($urandom);
                    if (drop) start = 1'b0;
                end
                CmdRead: begin rd_c = cyc; rd_ba = ba; rd_a = sd_addr; end
                CmdBst:  begin bst_c = cyc; bst_ba = ba; end
                CmdPre:  begin pre_c = cyc; pre_ba = ba; pre_a10 = sd_addr[10]; end
                CmdNop:  if (ba != 2'b11 || sd_addr != 13'h1FFF) bad_bus++;
                default: bad_bus++;
            endcase
            if (ack) begin
                if (first_ack < 0) first_ack = cyc;
                else if (cyc != last_ack + 1) gaps++;
                if (rdata != mem_word(eba, erow, 9'(int'(ecol) + n_ack))) bad_data++;
                n_ack++;
                last_ack = cyc;
            end
            if (done) begin
                n_done++;
                done_c = cyc;
                start  = 1'b0;
                if (post < 0) post = 3;
            end
            if (post == 0) break;
            if (post > 0) post--;
        end
        start = 1'b0;
        chk({tag, "/act_count"}, n_act, 1);
        chk({tag, "/act_ba"}, int'(act_ba), int'(eba));
        chk({tag, "/act_row"}, int'(act_a), int'(erow));
        chk({tag, "/act_to_read"}, rd_c - act_c, TRCD);
        chk({tag, "/read_addr"}, int'(rd_a), int'(ecol));
        chk({tag, "/read_ba"}, int'(rd_ba), int'(eba));
        chk({tag, "/read_to_bst"}, bst_c - rd_c, en);
        chk({tag, "/bst_ba"}, int'(bst_ba), int'(eba));
        chk({tag, "/ack_count"}, n_ack, en);
        chk({tag, "/read_to_first_ack"}, first_ack - rd_c, CAS + 1 + DLY);
        chk({tag, "/ack_gaps"}, gaps, 0);
        chk({tag, "/data_errors"}, bad_data, 0);
        chk({tag, "/read_to_pre"}, pre_c - rd_c, CAS + en + DLY);
        chk({tag, "/pre_ba"}, int'(pre_ba), int'(eba));
        chk({tag, "/pre_a10"}, int'(pre_a10), 0);
        chk({tag, "/pre_to_done"}, done_c - pre_c, TRP);
        chk({tag, "/done_count"}, n_done, 1);
        chk({tag, "/idle_bus_errors"}, bad_bus, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "/cmd"}, int'(cmd), int'(CmdNop));
        chk({tag, "/ba"}, int'(ba), 3);
        chk({tag, "/addr"}, int'(sd_addr), 'h1FFF);
        chk({tag, "/data"}, int'(rdata), 0);
        chk({tag, "/ack"}, int'(ack), 0);
        chk({tag, "/done"}, int'(done), 0);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [9:0]  len;
        logic [1:0]  exp_ba;
        logic [12:0] exp_row;
        logic [8:0]  exp_col;
        int          exp_n;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int   n;
        int   mode;
        logic [23:0] ra;
        logic [9:0]  rl;

        vecs[0] = '{24'h000000, 10'd10,  2'd0, 13'h0000, 9'h000, 10};
        vecs[1] = '{24'h400203, 10'd4,   2'd1, 13'h0001, 9'h003, 4};
        vecs[2] = '{24'h000000, 10'd0,   2'd0, 13'h0000, 9'h000, 1};
        vecs[3] = '{24'h8005F0, 10'd600, 2'd2, 13'h0002, 9'h1F0, 512};
        vecs[4] = '{24'hFFFFFF, 10'd3,   2'd3, 13'h1FFF, 9'h1FF, 3};

        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start without init must be ignored.
        start = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd != CmdNop || ack || done) n++;
        end
        chk("guard/activity", n, 0);
        start = 1'b0;
        @(negedge clk);
        init_done = 1'b1;

        for (int v = 0; v < 5; v++)
            run_xfer($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].exp_ba,
                     vecs[v].exp_row, vecs[v].exp_col, vecs[v].exp_n, 1'b0);

        run_xfer("drop", 24'h0C0A10, 10'd20, 2'd0, 13'h0605, 9'h010, 20, 1'b1);

        for (int t = 0; t < 8; t++) begin
            ra   = 24'($urandom);
            mode = $urandom_range(0, 5);
            if (mode == 0) rl = 10'd0;
            else if (mode == 1) rl = 10'($urandom_range(513, 1023));
            else rl = 10'($urandom_range(1, 40));
            run_xfer($sformatf("rnd%0d", t), ra, rl, ra[23:22], ra[21:9], ra[8:0],
                     clamp_len(int'(rl)), 1'b0);
        end

        // Reset asserted mid-cycle during the fifth ack.
        @(negedge clk);
        rd_addr   = 24'h123456;
        burst_len = 10'd10;
        start     = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack) n++;
            if (n == 5) break;
        end
        chk("midrst/fifth_ack_seen", n, 5);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        start     = 1'b0;
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        init_done = 1'b1;
        run_xfer("post_rst", 24'h123456, 10'd10, 2'd0, 13'h091A, 9'h056, 10, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
